fetch_decode_buffer: RTL and testbench

FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

---
 rtl/fetch_decode_buffer.sv | 95 +++++++++
 tb/tb_fetch_decode_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_buffer.sv
// Two-entry in-order {pc, instruction} buffer between fetcher and decoder.
// Slot 0 is always the head; slot 1 holds the entry behind it.
// in_ready and out_valid depend only on registered occupancy (and reset).
module fetch_decode_buffer #(
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int PC_BITS               = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [PC_BITS-1:0]               in_pc,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] in_instruction,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [PC_BITS-1:0]               out_pc,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] out_instruction,
    output logic [1:0]                       occupancy
);

    logic [1:0]                       occ_q, occ_d;
    logic [PC_BITS-1:0]               pc0_q, pc0_d, pc1_q, pc1_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] ins0_q, ins0_d, ins1_q, ins1_d;
    logic                             push, pop;

    // Handshake flags from registered occupancy; reset blocks acceptance.
    always_comb begin
        in_ready  = ~reset && (occ_q != 2'd2);
        out_valid = (occ_q != 2'd0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Next-state: flush wins, otherwise shift/append based on push and pop.
    always_comb begin
        occ_d  = occ_q;
        pc0_d  = pc0_q;
        pc1_d  = pc1_q;
        ins0_d = ins0_q;
        ins1_d = ins1_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        pc0_d  = in_pc;
                        ins0_d = in_instruction;
                    end else begin
                        pc1_d  = in_pc;
                        ins1_d = in_instruction;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    pc0_d  = pc1_q;
                    ins0_d = ins1_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    // Only reachable at occupancy 1: the pushed entry replaces the head.
                    pc0_d  = in_pc;
                    ins0_d = in_instruction;
                end
                default: ;
            endcase
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q  <= '0;
            pc0_q  <= '0;
            pc1_q  <= '0;
            ins0_q <= '0;
            ins1_q <= '0;
        end else begin
            occ_q  <= occ_d;
            pc0_q  <= pc0_d;
            pc1_q  <= pc1_d;
            ins0_q <= ins0_d;
            ins1_q <= ins1_d;
        end
    end

    // Head presentation, zeroed when empty.
    always_comb begin
        occupancy       = occ_q;
        out_pc          = out_valid ? pc0_q  : '0;
        out_instruction = out_valid ? ins0_q : '0;
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed and randomized checks for fetch_decode_buffer.
module tb_fetch_decode_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pc;
    logic [15:0] in_instruction;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pc;
    logic [15:0] out_instruction;
    logic [1:0]  occupancy;

    int total = 0;
    int bad   = 0;

    fetch_decode_buffer #(
        .PROGRAM_MEM_DATA_BITS(16),
        .PC_BITS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pc(in_pc),
        .in_instruction(in_instruction),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_instruction(out_instruction),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Observed state packed as {out_valid, occupancy, in_ready, out_pc, out_instruction}.
    logic [27:0] obs;
    always_comb obs = {out_valid, occupancy, in_ready, out_pc, out_instruction};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_pc = '0; in_instruction = '0;
        flush = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #3;
        if (obs !== 28'h0) begin bad++; $display("FAIL reset_hold got=%h exp=%h", obs, 28'h0); end
        total++;
        tick(); tick();
        reset = 1'b0;
        #1;
        if (obs !== {1'b0, 2'd0, 1'b1, 8'h00, 16'h0000}) begin
            bad++; $display("FAIL reset_release got=%h exp=%h", obs, {1'b0, 2'd0, 1'b1, 24'h0});
        end
        total++;
    endtask

    task automatic test_pass_through();
        idle();
        in_valid = 1'b1; in_pc = 8'h05; in_instruction = 16'h3A1F; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        if (obs !== {1'b1, 2'd1, 1'b1, 8'h05, 16'h3A1F}) begin
            bad++; $display("FAIL pass_head got=%h exp=%h", obs, {1'b1, 2'd1, 1'b1, 8'h05, 16'h3A1F});
        end
        total++;
        tick();
        if (obs !== {1'b0, 2'd0, 1'b1, 24'h0}) begin
            bad++; $display("FAIL pass_drained got=%h exp=%h", obs, {1'b0, 2'd0, 1'b1, 24'h0});
        end
        total++;
    endtask

    task automatic test_backpressure();
        idle();
        in_valid = 1'b1; in_pc = 8'h10; in_instruction = 16'h1111;
        tick();
        if (obs !== {1'b1, 2'd1, 1'b1, 8'h10, 16'h1111}) begin
            bad++; $display("FAIL bp_one got=%h exp=%h", obs, {1'b1, 2'd1, 1'b1, 8'h10, 16'h1111});
        end
        total++;
        in_pc = 8'h11; in_instruction = 16'h2222;
        tick();
        if (obs !== {1'b1, 2'd2, 1'b0, 8'h10, 16'h1111}) begin
            bad++; $display("FAIL bp_full got=%h exp=%h", obs, {1'b1, 2'd2, 1'b0, 8'h10, 16'h1111});
        end
        total++;
        in_pc = 8'h12; in_instruction = 16'h3333;
        tick();
        if (obs !== {1'b1, 2'd2, 1'b0, 8'h10, 16'h1111}) begin
            bad++; $display("FAIL bp_ignore3 got=%h exp=%h", obs, {1'b1, 2'd2, 1'b0, 8'h10, 16'h1111});
        end
        total++;
        // Pop at full with in_valid still high: pop only, no push.
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        if (obs !== {1'b1, 2'd1, 1'b1, 8'h11, 16'h2222}) begin
            bad++; $display("FAIL bp_drain1 got=%h exp=%h", obs, {1'b1, 2'd1, 1'b1, 8'h11, 16'h2222});
        end
        total++;
        tick();
        if (obs !== {1'b0, 2'd0, 1'b1, 24'h0}) begin
            bad++; $display("FAIL bp_drain2 got=%h exp=%h", obs, {1'b0, 2'd0, 1'b1, 24'h0});
        end
        total++;
    endtask

    task automatic test_push_pop();
        idle();
        in_valid = 1'b1; in_pc = 8'h20; in_instruction = 16'hAAAA;
        tick();
        in_pc = 8'h21; in_instruction = 16'hBBBB; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        if (obs !== {1'b1, 2'd1, 1'b1, 8'h21, 16'hBBBB}) begin
            bad++; $display("FAIL pushpop got=%h exp=%h", obs, {1'b1, 2'd1, 1'b1, 8'h21, 16'hBBBB});
        end
        total++;
        tick();
        if (obs !== {1'b0, 2'd0, 1'b1, 24'h0}) begin
            bad++; $display("FAIL pushpop_drain got=%h exp=%h", obs, {1'b0, 2'd0, 1'b1, 24'h0});
        end
        total++;
    endtask

    task automatic test_flush();
        idle();
        in_valid = 1'b1; in_pc = 8'h2E; in_instruction = 16'h1234;
        tick();
        in_pc = 8'h2F; in_instruction = 16'h5678;
        tick();
        if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_fill got=%0d exp=2", occupancy); end
        total++;
        flush = 1'b1; in_pc = 8'h30; in_instruction = 16'hCCCC; out_ready = 1'b1;
        tick();
        idle();
        if (obs !== {1'b0, 2'd0, 1'b1, 24'h0}) begin
            bad++; $display("FAIL flush_empty got=%h exp=%h", obs, {1'b0, 2'd0, 1'b1, 24'h0});
        end
        total++;
        tick();
        if (obs !== {1'b0, 2'd0, 1'b1, 24'h0}) begin
            bad++; $display("FAIL flush_stays got=%h exp=%h", obs, {1'b0, 2'd0, 1'b1, 24'h0});
        end
        total++;
    endtask

    task automatic test_async_reset();
        idle();
        in_valid = 1'b1; in_pc = 8'h40; in_instruction = 16'h4444;
        tick();
        in_pc = 8'h41; in_instruction = 16'h5555;
        tick();
        in_valid = 1'b0;
        if (occupancy !== 2'd2) begin bad++; $display("FAIL ares_fill got=%0d exp=2", occupancy); end
        total++;
        #1 reset = 1'b1;
        #1;
        if (obs !== 28'h0) begin bad++; $display("FAIL ares_now got=%h exp=%h", obs, 28'h0); end
        total++;
        #1 reset = 1'b0;
        #1;
        if (obs !== {1'b0, 2'd0, 1'b1, 24'h0}) begin
            bad++; $display("FAIL ares_release got=%h exp=%h", obs, {1'b0, 2'd0, 1'b1, 24'h0});
        end
        total++;
    endtask

    task automatic test_stress();
        logic [23:0] q[$];
        logic [27:0] exp_obs;
        logic        push, pop;
        int          errs;
        errs = 0;
        idle();
        for (int i = 0; i < 400; i++) begin
            in_valid       = ($urandom % 4) != 0;
            out_ready      = ($urandom % 3) != 0;
            flush          = ($urandom % 16) == 0;
            in_pc          = 8'($urandom);
            in_instruction = 16'($urandom);
            #1;
            if (q.size() != 0)
                exp_obs = {1'b1, 2'(q.size()), q.size() != 2, q[0]};
            else
                exp_obs = {1'b0, 2'd0, 1'b1, 24'h0};
            if (obs !== exp_obs) begin
                bad++;
                if (errs < 10) $display("FAIL stress_cyc%0d got=%h exp=%h", i, obs, exp_obs);
                errs++;
            end
            total++;
            push = in_valid && (q.size() != 2);
            pop  = out_ready && (q.size() != 0);
            tick();
            if (flush) q.delete();
            else begin
                if (pop)  void'(q.pop_front());
                if (push) q.push_back({in_pc, in_instruction});
            end
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_pass_through();
        test_backpressure();
        test_push_pop();
        test_flush();
        test_async_reset();
        test_stress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
